// File: rtl/ls_axi_bridge.sv
`default_nettype none
// ============================================================================
// ls_axi_bridge : core load/store port to single-beat AXI master, posted
//                 write buffer with load ordering and flush-safe loads
// Revision      : 1.0
// ============================================================================
module ls_axi_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_load_enable,
    input  logic                  io_store_enable,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W/8-1:0]   io_store_sel,
    input  logic [DATA_W-1:0]     io_store_data,
    input  logic                  io_cached,
    input  logic                  io_flush,
    output logic                  io_load_rValid,
    output logic [DATA_W-1:0]     io_load_data,
    output logic                  io_store_bValid,
    output logic                  io_wb_empty,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(WB_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_WAIT = 3'd1,
        LD_AR   = 3'd2,
        LD_R    = 3'd3,
        LD_RSP  = 3'd4
    } ld_state_t;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_ADDR = 2'd1,
        DR_RESP = 2'd2
    } dr_state_t;

    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [STRB_W-1:0] wb_sel_q  [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wb_empty_q, wb_empty_d;

    dr_state_t         dr_state_q, dr_state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    ld_state_t         ld_state_q, ld_state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              discard_q, discard_d;

    logic              push, pop, hazard;

    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign pop             = (dr_state_q == DR_RESP) && m_bvalid;
    assign push            = io_store_enable && !io_load_enable && !io_flush &&
                             ((count_q < CNT_W'(WB_DEPTH)) || pop);
    assign io_store_bValid = push;
    assign io_wb_empty     = wb_empty_q;
    assign io_load_data    = ld_data_q;
    assign m_araddr        = ld_addr_q;
    assign m_awaddr        = wb_addr_q[head_q];
    assign m_wdata         = wb_data_q[head_q];
    assign m_wstrb         = wb_sel_q[head_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // The head entry stays counted until its B arrives, which covers the in-flight write.
    always_comb begin
        logic [PTR_W-1:0] slot;
        hazard = 1'b0;
        slot   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (wb_addr_q[slot][ADDR_W-1:OFF_W] == io_addr[ADDR_W-1:OFF_W])) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        dr_state_d = dr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        m_awvalid  = (dr_state_q == DR_ADDR) && !aw_done_q;
        m_wvalid   = (dr_state_q == DR_ADDR) && !w_done_q;
        m_bready   = (dr_state_q == DR_RESP);
        case (dr_state_q)
            DR_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if ((count_q != '0) || push) begin
                    dr_state_d = DR_ADDR;
                end
            end
            DR_ADDR: begin
                aw_done_d = aw_done_q || (m_awvalid && m_awready);
                w_done_d  = w_done_q || (m_wvalid && m_wready);
                if (aw_done_d && w_done_d) begin
                    dr_state_d = DR_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            DR_RESP: begin
                if (m_bvalid) begin
                    dr_state_d = DR_IDLE;
                end
            end
            default: dr_state_d = DR_IDLE;
        endcase
        wb_empty_d = (count_d == '0) && (dr_state_d == DR_IDLE);
    end

    always_comb begin
        ld_state_d     = ld_state_q;
        ld_addr_d      = ld_addr_q;
        ld_data_d      = ld_data_q;
        discard_d      = discard_q;
        m_arvalid      = (ld_state_q == LD_AR);
        m_rready       = (ld_state_q == LD_R);
        io_load_rValid = (ld_state_q == LD_RSP) && !discard_q && !io_flush;
        case (ld_state_q)
            LD_IDLE: begin
                discard_d = 1'b0;
                if (io_load_enable && !io_flush) begin
                    ld_addr_d  = io_addr;
                    ld_state_d = (hazard || !io_cached) ? LD_WAIT : LD_AR;
                end
            end
            LD_WAIT: begin
                if (io_flush) begin
                    ld_state_d = LD_IDLE;
                end else if (wb_empty_q) begin
                    ld_state_d = LD_AR;
                end
            end
            LD_AR: begin
                // An issued AR must complete its handshake even when flushed.
                if (io_flush) begin
                    discard_d = 1'b1;
                end
                if (m_arready) begin
                    ld_state_d = LD_R;
                end
            end
            LD_R: begin
                if (io_flush) begin
                    discard_d = 1'b1;
                end
                if (m_rvalid) begin
                    if (discard_q || io_flush) begin
                        ld_state_d = LD_IDLE;
                    end else begin
                        ld_data_d  = m_rdata;
                        ld_state_d = LD_RSP;
                    end
                end
            end
            LD_RSP: begin
                ld_state_d = LD_IDLE;
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_sel_q[i]  <= '0;
                wb_data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wb_empty_q <= 1'b1;
            dr_state_q <= DR_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ld_state_q <= LD_IDLE;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
            discard_q  <= 1'b0;
        end else begin
            if (push) begin
                wb_addr_q[tail_q] <= io_addr;
                wb_sel_q[tail_q]  <= io_store_sel;
                wb_data_q[tail_q] <= io_store_data;
                tail_q            <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q    <= count_d;
            wb_empty_q <= wb_empty_d;
            dr_state_q <= dr_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ld_state_q <= ld_state_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            discard_q  <= discard_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ls_axi_bridge.sv
`default_nettype none
// ============================================================================
// tb_ls_axi_bridge : scoreboard bench for ls_axi_bridge with a small AXI slave
// Revision         : 1.0
// ============================================================================
module tb_ls_axi_bridge;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_load_enable, io_store_enable, io_cached, io_flush;
    logic [31:0] io_addr, io_store_data;
    logic [3:0]  io_store_sel;
    logic        io_load_rValid, io_store_bValid, io_wb_empty;
    logic [31:0] io_load_data;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_wstrb;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        aw_en, w_en;
    int          ar_delay;
    logic [31:0] rd_data;
    logic        aw_got, w_got, bvalid_r, r_pend;
    int          ar_cnt;

    wr_t         exp_wr[$];
    logic [31:0] exp_ld[$];
    logic [31:0] exp_araddr;
    int          mon_b_count = 0;
    int          last_b_cyc = -1;
    int          ar_first_cyc = -1;
    int          rv_count = 0;
    logic        ar_prev = 1'b0;

    ls_axi_bridge #(.ADDR_W(32), .DATA_W(32), .WB_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .io_load_enable(io_load_enable), .io_store_enable(io_store_enable),
        .io_addr(io_addr), .io_store_sel(io_store_sel), .io_store_data(io_store_data),
        .io_cached(io_cached), .io_flush(io_flush),
        .io_load_rValid(io_load_rValid), .io_load_data(io_load_data),
        .io_store_bValid(io_store_bValid), .io_wb_empty(io_wb_empty),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign m_awready = aw_en;
    assign m_wready  = w_en;
    assign m_bvalid  = bvalid_r;
    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign m_rvalid  = r_pend;
    assign m_rdata   = rd_data;

    always @(posedge clock) begin
        if (reset) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; r_pend <= 1'b0; ar_cnt <= 0;
        end else begin
            if (m_awvalid && m_awready) aw_got <= 1'b1;
            if (m_wvalid && m_wready) w_got <= 1'b1;
            if (bvalid_r && m_bready) begin
                bvalid_r <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (aw_got && w_got) begin
                bvalid_r <= 1'b1;
            end
            if (m_arvalid && !m_arready) ar_cnt <= ar_cnt + 1;
            else ar_cnt <= 0;
            if (m_arvalid && m_arready) r_pend <= 1'b1;
            else if (r_pend && m_rready) r_pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: compare bus traffic and load returns against queued expectations.
    always @(negedge clock) begin
        if (!reset) begin
            if (m_awvalid && m_awready) begin
                if (exp_wr.size() == 0) check("wr_unexpected_aw", 1, 0);
                else check("awaddr", m_awaddr, exp_wr[0].addr);
            end
            if (m_wvalid && m_wready) begin
                if (exp_wr.size() == 0) check("wr_unexpected_w", 1, 0);
                else begin
                    check("wstrb", m_wstrb, exp_wr[0].sel);
                    check("wdata", m_wdata, exp_wr[0].data);
                end
            end
            if (m_bvalid && m_bready) begin
                if (exp_wr.size() != 0) exp_wr.delete(0);
                mon_b_count++;
                last_b_cyc = cyc;
            end
            if (m_arvalid && !ar_prev) ar_first_cyc = cyc;
            ar_prev = m_arvalid;
            if (m_arvalid && m_arready) check("araddr", m_araddr, exp_araddr);
            if (io_load_rValid) begin
                rv_count++;
                if (exp_ld.size() == 0) check("rvalid_unexpected", 1, 0);
                else check("ld_data", io_load_data, exp_ld.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, output int acc);
        wr_t e;
        bit  ok = 1'b0;
        io_store_enable = 1'b1; io_addr = a; io_store_sel = s; io_store_data = d;
        acc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (io_store_bValid) begin acc = cyc; ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("store_timeout", 0, 1);
        else begin
            e.addr = a; e.sel = s; e.data = d;
            exp_wr.push_back(e);
            tick();
        end
        io_store_enable = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic c, input logic [31:0] d,
                           input int rel, output int iss, output int dn);
        bit ok = 1'b0;
        rd_data = d; exp_araddr = a; exp_ld.push_back(d);
        io_load_enable = 1'b1; io_addr = a; io_cached = c;
        iss = cyc; dn = -1;
        for (int k = 0; k < 300; k++) begin
            if (k == rel) begin aw_en = 1'b1; w_en = 1'b1; end
            @(negedge clock);
            if (io_load_rValid) begin dn = cyc; ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin check("load_timeout", 0, 1); exp_ld.delete(); end
        tick();
        io_load_enable = 1'b0;
    endtask

    task automatic wait_writes(input int n, output int last);
        int seen = 0;
        last = -1;
        for (int k = 0; k < 500 && seen < n; k++) begin
            @(negedge clock);
            if (m_bvalid && m_bready) begin seen++; last = cyc; end
        end
        check("write_timeout", seen, n);
    endtask

    initial begin
        int a0, a1, a2, a3, acc, iss, dn, lb, b0, rv0, t0;
        bit ok;
        reset = 1'b1; io_load_enable = 1'b0; io_store_enable = 1'b0; io_cached = 1'b1;
        io_flush = 1'b0; io_addr = '0; io_store_sel = '0; io_store_data = '0;
        aw_en = 1'b0; w_en = 1'b0; ar_delay = 0; rd_data = '0; exp_araddr = '0;
        repeat (3) tick();
        @(negedge clock);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_rready", m_rready, 0);
        check("rst_rvalid", io_load_rValid, 0);
        check("rst_wb_empty", io_wb_empty, 1);
        check("rst_load_data", io_load_data, 0);
        tick();
        reset = 1'b0;
        tick();

        // Four back-to-back stores into a stalled bus, then a fifth while full.
        do_store(32'h0000_0010, 4'b0001, 32'h1111_0001, a0);
        do_store(32'h0000_0014, 4'b0011, 32'h2222_0002, a1);
        do_store(32'h0000_0018, 4'b1111, 32'h3333_0003, a2);
        do_store(32'h0000_001C, 4'b1000, 32'h4444_0004, a3);
        check("t1_consec1", a1 - a0, 1);
        check("t1_consec2", a2 - a0, 2);
        check("t1_consec3", a3 - a0, 3);
        io_store_enable = 1'b1; io_addr = 32'h20; io_store_sel = 4'hF; io_store_data = 32'h5;
        @(negedge clock);
        check("t1_full_bvalid", io_store_bValid, 0);
        tick();
        io_store_enable = 1'b0;
        aw_en = 1'b1; w_en = 1'b1;
        wait_writes(4, lb);
        check("t1_empty_at_last_b", io_wb_empty, 0);
        @(negedge clock);
        check("t1_empty_after_last_b", io_wb_empty, 1);
        tick();

        // Cached load to an unrelated word bypasses the buffered store.
        aw_en = 1'b0; w_en = 1'b0;
        do_store(32'h0000_0200, 4'b1111, 32'hCAFE_0001, a0);
        do_load(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, -1, iss, dn);
        check("t2_latency", dn - iss, 3);
        check("t2_before_drain", io_wb_empty, 0);
        aw_en = 1'b1; w_en = 1'b1;
        wait_writes(1, lb);
        tick();

        // Cached load to a buffered word waits for that write's B.
        aw_en = 1'b0; w_en = 1'b0;
        do_store(32'h0000_0104, 4'b0110, 32'h5555_AAAA, a0);
        do_load(32'h0000_0104, 1'b1, 32'h0BAD_F00D, 4, iss, dn);
        check("t3_ar_after_b", ar_first_cyc, last_b_cyc + 2);

        // Uncached load waits for both buffered writes.
        aw_en = 1'b0; w_en = 1'b0;
        do_store(32'h0000_0300, 4'b0001, 32'h0000_0033, a0);
        do_store(32'h0000_0304, 4'b1100, 32'h4400_0000, a1);
        b0 = mon_b_count;
        do_load(32'h0000_0500, 1'b0, 32'h600D_CAFE, 3, iss, dn);
        check("t4_two_b_first", mon_b_count - b0, 2);
        check("t4_ar_after_b", ar_first_cyc, last_b_cyc + 2);

        // Flush one cycle into a slow AR: handshake completes, no rValid.
        ar_delay = 3; rv0 = rv_count; exp_araddr = 32'h600;
        io_load_enable = 1'b1; io_addr = 32'h600; io_cached = 1'b1;
        tick();
        @(negedge clock);
        check("t5_arvalid_c1", m_arvalid, 1);
        tick();
        io_flush = 1'b1; io_load_enable = 1'b0;
        @(negedge clock);
        check("t5_arvalid_c2", m_arvalid, 1);
        tick();
        io_flush = 1'b0;
        @(negedge clock);
        check("t5_arvalid_c3", m_arvalid, 1);
        tick();
        @(negedge clock);
        check("t5_ar_hs", m_arvalid && m_arready, 1);
        tick();
        @(negedge clock);
        check("t5_r_hs", m_rvalid && m_rready, 1);
        tick();
        @(negedge clock);
        check("t5_idle_ar", m_arvalid, 0);
        check("t5_idle_r", m_rready, 0);
        repeat (4) tick();
        check("t5_no_rvalid", rv_count - rv0, 0);
        check("t5_r_consumed", r_pend, 0);
        ar_delay = 0;
        do_load(32'h0000_0700, 1'b1, 32'h1357_2468, -1, iss, dn);
        check("t5_next_latency", dn - iss, 3);

        // Store while full coinciding with a pop, then reset mid-drain.
        aw_en = 1'b0; w_en = 1'b0;
        do_store(32'h0000_0800, 4'b0001, 32'hA000_0000, a0);
        do_store(32'h0000_0804, 4'b0010, 32'hA000_0001, a1);
        do_store(32'h0000_0808, 4'b0100, 32'hA000_0002, a2);
        do_store(32'h0000_080C, 4'b1000, 32'hA000_0003, a3);
        io_store_enable = 1'b1; io_addr = 32'h810; io_store_sel = 4'hF; io_store_data = 32'hA000_0004;
        aw_en = 1'b1; w_en = 1'b1;
        @(negedge clock);
        check("t6_full_no_pop", io_store_bValid, 0);
        tick();
        aw_en = 1'b0; w_en = 1'b0;
        ok = 1'b0; acc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (io_store_bValid) begin acc = cyc; ok = 1'b1; break; end
            tick();
        end
        check("t6_accept_seen", ok, 1);
        tick();
        exp_wr.push_back('{addr: 32'h810, sel: 4'hF, data: 32'hA000_0004});
        check("t6_accept_in_pop_cycle", acc, last_b_cyc);
        io_addr = 32'h814; io_store_data = 32'hA000_0005;
        t0 = 0;
        repeat (3) begin
            @(negedge clock);
            t0 += int'(io_store_bValid);
            tick();
        end
        check("t6_count_still_full", t0, 0);
        reset = 1'b1; io_store_enable = 1'b0;
        exp_wr.delete();
        tick();
        @(negedge clock);
        check("t7_awvalid", m_awvalid, 0);
        check("t7_wvalid", m_wvalid, 0);
        check("t7_bready", m_bready, 0);
        check("t7_arvalid", m_arvalid, 0);
        check("t7_rready", m_rready, 0);
        check("t7_wb_empty", io_wb_empty, 1);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
